complex_mag_est: RTL and testbench

COMPLEX_MAG_EST -- requirements
Module: complex_mag_est

---
 rtl/complex_mag_est.sv | 145 ++++++++++++++
 tb/tb_complex_mag_est.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mag_est.sv
// Pipelined alpha-max-plus-beta-min magnitude estimator with windowed mean.
// Define COMPLEX_MAG_PEAK_EN to add the windowed-maximum output peak_mag.
`timescale 1ns/1ps
module complex_mag_est #(
    parameter int DATA_WIDTH = 16,
    parameter int AVG_LOG2   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] i,
    input  logic signed [DATA_WIDTH-1:0] q,
    input  logic                         input_strobe,
    input  logic [1:0]                   mode,
    output logic [DATA_WIDTH:0]          mag,
    output logic                         mag_stb,
    output logic [DATA_WIDTH:0]          avg_mag,
    output logic                         avg_stb
`ifdef COMPLEX_MAG_PEAK_EN
    ,
    output logic [DATA_WIDTH:0]          peak_mag
`endif
);

    localparam int MW = DATA_WIDTH + 1;
    localparam int AW = DATA_WIDTH + 1 + AVG_LOG2;
    localparam int EW = DATA_WIDTH + 5;
    localparam logic [EW-1:0] C3  = 3;
    localparam logic [EW-1:0] C15 = 15;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
    localparam logic [AVG_LOG2-1:0] CNT_ONE  = 1;

    logic [DATA_WIDTH-1:0] neg_i, neg_q, abs_i_n, abs_q_n;
    logic [DATA_WIDTH-1:0] abs_i_r, abs_q_r, max_r, min_r;
    logic [1:0]            mode_s1, mode_s2;
    logic                  v1, v2, v3;
    logic [MW-1:0]         mag_r;
    logic [EW-1:0]         mx_e, mn_e, est;
    logic [AW-1:0]         acc, sum;
    logic [AVG_LOG2-1:0]   cnt;
    logic                  last;
    logic [MW-1:0]         avg_r;
    logic                  avg_v;

    // Two's-complement negate; the most negative input becomes 2^(W-1) unsigned.
    assign neg_i   = $unsigned(-i);
    assign neg_q   = $unsigned(-q);
    assign abs_i_n = i[DATA_WIDTH-1] ? neg_i : $unsigned(i);
    assign abs_q_n = q[DATA_WIDTH-1] ? neg_q : $unsigned(q);

    always_comb begin
        mx_e = {5'b0, max_r};
        mn_e = {5'b0, min_r};
        est  = '0;
        case (mode_s2)
            2'd0:    est = mx_e + (mn_e >> 2);
            2'd1:    est = mx_e + (mn_e >> 1);
            2'd2:    est = mx_e + ((C3 * mn_e) >> 3);
            default: est = ((C15 * mx_e) >> 4) + ((C15 * mn_e) >> 5);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            abs_i_r <= '0;
            abs_q_r <= '0;
            mode_s1 <= '0;
            v1      <= 1'b0;
            max_r   <= '0;
            min_r   <= '0;
            mode_s2 <= '0;
            v2      <= 1'b0;
            mag_r   <= '0;
            v3      <= 1'b0;
        end else if (enable) begin
            abs_i_r <= abs_i_n;
            abs_q_r <= abs_q_n;
            mode_s1 <= mode;
            v1      <= input_strobe;
            max_r   <= (abs_i_r >= abs_q_r) ? abs_i_r : abs_q_r;
            min_r   <= (abs_i_r >= abs_q_r) ? abs_q_r : abs_i_r;
            mode_s2 <= mode_s1;
            v2      <= v1;
            mag_r   <= MW'(est);
            v3      <= v2;
        end
    end

    assign mag_stb = v3 & enable & ~reset;
    assign last    = (cnt == CNT_LAST);
    assign sum     = acc + AW'(mag_r);

    // Window bookkeeping advances only on emitted samples, so holds stall it too.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            avg_r <= '0;
        end else if (mag_stb) begin
            if (last) begin
                avg_r <= MW'(sum >> AVG_LOG2);
                acc   <= '0;
                cnt   <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            avg_v <= 1'b0;
        end else if (enable) begin
            avg_v <= mag_stb & last;
        end
    end

    assign avg_stb = avg_v & enable & ~reset;
    assign mag     = reset ? '0 : mag_r;
    assign avg_mag = reset ? '0 : avg_r;

`ifdef COMPLEX_MAG_PEAK_EN
    logic [MW-1:0] run_peak, peak_r, new_peak;

    assign new_peak = (run_peak > mag_r) ? run_peak : mag_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            run_peak <= '0;
            peak_r   <= '0;
        end else if (mag_stb) begin
            if (last) begin
                peak_r   <= new_peak;
                run_peak <= '0;
            end else begin
                run_peak <= new_peak;
            end
        end
    end

    assign peak_mag = reset ? '0 : peak_r;
`endif

endmodule

// File: tb/tb_complex_mag_est.sv
// Directed bench for complex_mag_est: vector table plus reset, window and stall sequences.
`timescale 1ns/1ps
module tb_complex_mag_est;
  localparam int DW = 16;
  localparam int AL = 2;
  localparam int MW = DW + 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic signed [DW-1:0] i;
  logic signed [DW-1:0] q;
  logic                 input_strobe;
  logic [1:0]           mode;
  logic [MW-1:0]        mag;
  logic                 mag_stb;
  logic [MW-1:0]        avg_mag;
  logic                 avg_stb;
`ifdef COMPLEX_MAG_PEAK_EN
  logic [MW-1:0]        peak_mag;
`endif

  complex_mag_est #(.DATA_WIDTH(DW), .AVG_LOG2(AL)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .i(i),
    .q(q),
    .input_strobe(input_strobe),
    .mode(mode),
    .mag(mag),
    .mag_stb(mag_stb),
    .avg_mag(avg_mag),
    .avg_stb(avg_stb)
`ifdef COMPLEX_MAG_PEAK_EN
    ,
    .peak_mag(peak_mag)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    int vi;
    int vq;
    int vm;
    int vexp;
  } vec_t;
  vec_t vecs[13];

  // scoreboard state
  logic [MW-1:0] exp_q[$];
  int            due_q[$];
  logic [MW-1:0] avg_exp_q[$];
  logic [MW-1:0] pk_exp_q[$];
  int            avg_due_q[$];
  int            ncyc = 0;
  int            nvec = 0;
  int            nfail = 0;
  int            win_n = 0;
  int            win_sum = 0;
  int            win_pk = 0;
  bit            chk_off = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // monitor: compare on the falling edge, away from the active edge
  initial begin
    logic [MW-1:0] em;
    int            d;
    forever begin
      @(negedge clock);
      ncyc++;
      if (mag_stb === 1'b1) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL mag_extra: got mag_stb with mag %0d, expected no output (cycle %0d)", mag, ncyc);
        end else begin
          em = exp_q.pop_front();
          d  = due_q.pop_front();
          check("mag", 32'(mag), 32'(em));
          if (d > 0) check("mag_lat", ncyc, d);
          win_sum += int'(em);
          if (int'(em) > win_pk) win_pk = int'(em);
          win_n++;
          if (win_n == (1 << AL)) begin
            avg_exp_q.push_back(MW'(win_sum >> AL));
            pk_exp_q.push_back(MW'(win_pk));
            avg_due_q.push_back(ncyc + 1);
            win_n   = 0;
            win_sum = 0;
            win_pk  = 0;
          end
        end
      end
      if (avg_stb === 1'b1) begin
        if (avg_exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL avg_extra: got avg_stb with avg %0d, expected none (cycle %0d)", avg_mag, ncyc);
        end else begin
          em = avg_exp_q.pop_front();
          d  = avg_due_q.pop_front();
          check("avg_mag", 32'(avg_mag), 32'(em));
          check("avg_lat", ncyc, d);
          em = pk_exp_q.pop_front();
`ifdef COMPLEX_MAG_PEAK_EN
          check("peak_mag", 32'(peak_mag), 32'(em));
`endif
        end
      end
      if (chk_off && enable === 1'b0) check("stb_off", {30'd0, avg_stb, mag_stb}, 32'd0);
    end
  end

  // driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic send(input int vi, input int vq, input int vm, input int e, input bit lat);
    i            = DW'(vi);
    q            = DW'(vq);
    mode         = 2'(vm);
    input_strobe = 1'b1;
    if (enable) begin
      exp_q.push_back(MW'(e));
      due_q.push_back(lat ? ncyc + 4 : 0);
    end
    @(posedge clock);
    #1;
    input_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    input_strobe = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    due_q.delete();
    avg_exp_q.delete();
    pk_exp_q.delete();
    avg_due_q.delete();
    win_n   = 0;
    win_sum = 0;
    win_pk  = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] en_pat;
    vecs[0]  = '{3, 4, 0, 4};
    vecs[1]  = '{3, 4, 1, 5};
    vecs[2]  = '{3, 4, 2, 5};
    vecs[3]  = '{3, 4, 3, 4};
    vecs[4]  = '{-32768, -32768, 1, 49152};
    vecs[5]  = '{-32768, -32768, 0, 40960};
    vecs[6]  = '{-32768, -32768, 2, 45056};
    vecs[7]  = '{-32768, -32768, 3, 46080};
    vecs[8]  = '{0, 0, 3, 0};
    vecs[9]  = '{100, -7, 0, 101};
    vecs[10] = '{-5, 5, 1, 7};
    vecs[11] = '{32767, 0, 3, 30719};
    vecs[12] = '{20, -12, 2, 24};

    reset        = 1'b1;
    enable       = 1'b1;
    input_strobe = 1'b1;
    i            = 16'sd1000;
    q            = 16'sd1000;
    mode         = 2'd1;
    repeat (4) @(posedge clock);
    #1;
    check("rst_mag", 32'(mag), 32'd0);
    check("rst_mag_stb", {31'd0, mag_stb}, 32'd0);
    check("rst_avg_mag", 32'(avg_mag), 32'd0);
    check("rst_avg_stb", {31'd0, avg_stb}, 32'd0);
`ifdef COMPLEX_MAG_PEAK_EN
    check("rst_peak_mag", 32'(peak_mag), 32'd0);
`endif
    input_strobe = 1'b0;
    reset        = 1'b0;
    idle(2);

    // back-to-back table, per-sample mode changes, 3-cycle latency
    for (int k = 0; k < 13; k++) send(vecs[k].vi, vecs[k].vq, vecs[k].vm, vecs[k].vexp, 1'b1);
    idle(8);

    // window 4,8,12,16 -> avg 10 / peak 16, then a clean 2,2,2,2 window
    do_reset();
    send(4, 0, 0, 4, 1'b1);
    send(8, 0, 0, 8, 1'b1);
    send(-12, 0, 0, 12, 1'b1);
    send(0, 16, 0, 16, 1'b1);
    send(2, 0, 0, 2, 1'b1);
    send(0, -2, 0, 2, 1'b1);
    send(2, 0, 0, 2, 1'b1);
    send(2, 1, 0, 2, 1'b1);
    idle(10);
    check("avg_hold", 32'(avg_mag), 32'd2);
`ifdef COMPLEX_MAG_PEAK_EN
    check("peak_hold", 32'(peak_mag), 32'd2);
`endif

    // partial window and an in-flight sample discarded by reset
    do_reset();
    send(100, 0, 0, 100, 1'b1);
    send(100, 0, 0, 100, 1'b1);
    idle(5);
    send(50, 0, 0, 50, 1'b1);
    do_reset();
    for (int k = 0; k < 4; k++) send(8, 0, 1, 8, 1'b1);
    idle(8);
    check("avg_after_reset", 32'(avg_mag), 32'd8);

    // strobes every cycle with enable stalls: accepted samples 1,4,5,8
    do_reset();
    en_pat  = 8'b1001_1001;
    chk_off = 1'b1;
    for (int k = 0; k < 8; k++) begin
      enable = en_pat[k];
      send(k + 1, 0, 0, k + 1, 1'b0);
    end
    enable = 1'b1;
    idle(8);
    chk_off = 1'b0;
    check("avg_stall", 32'(avg_mag), 32'd4);

    check("pending_outputs", exp_q.size() + avg_exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
